// File: rtl/haar_dwt_ctrl.sv
// haar_dwt_ctrl: one-level in-place 2D Haar DWT sequencer.
// Owns both image-memory ports; row pass first, then column pass.
module haar_dwt_ctrl #(
   parameter int HEIGHT = 256,
   parameter int WIDTH  = 256,
   localparam int AW = $clog2(HEIGHT * WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          mem_en1,
   output logic          mem_en2,
   output logic          mem_we1,
   output logic          mem_we2,
   output logic [AW-1:0] mem_addr1,
   output logic [AW-1:0] mem_addr2,
   output logic [7:0]    mem_din1,
   output logic [7:0]    mem_din2,
   input  logic [7:0]    mem_dout1,
   input  logic [7:0]    mem_dout2
);
   localparam int MAXN = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
   localparam int HALF = MAXN / 2;
   localparam int KW   = $clog2(HALF + 1);
   localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int LW   = $clog2(MAXN);

   typedef enum logic [2:0] {
      IDLE, ROW_RD, ROW_WR, COL_RD, COL_WR, DONE
   } state_t;

   state_t state, state_n;
   logic [KW-1:0] k, k_n;
   logic [LW-1:0] line, line_n;

   logic [7:0] lbuf [HALF];
   logic [7:0] hbuf [HALF];

   logic [8:0]        sum;
   logic signed [8:0] dif;
   logic [7:0]        l_new, h_new;
   logic              cap;
   logic [KW-1:0]     cap_idx;

   logic          en_n, we_n, busy_n, done_n, row_n;
   logic [AW-1:0] a1_n, a2_n;
   logic [7:0]    d1_n, d2_n;
   int            nh, kk, ln, p1, p2;

   assign sum   = {1'b0, mem_dout1} + {1'b0, mem_dout2};
   assign dif   = $signed({1'b0, mem_dout1}) - $signed({1'b0, mem_dout2});
   assign l_new = sum[8:1];
   assign h_new = 8'(dif >>> 1) + 8'd128;

   // read data lags the issued pair by one cycle
   assign cap     = (state == ROW_RD || state == COL_RD) && (k != '0);
   assign cap_idx = k - KW'(1);

   always_ff @(posedge clk) begin
      if (cap) begin
         lbuf[cap_idx[BW-1:0]] <= l_new;
         hbuf[cap_idx[BW-1:0]] <= h_new;
      end
   end

   always_comb begin
      state_n = state;
      k_n     = k;
      line_n  = line;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = ROW_RD;
               k_n     = '0;
               line_n  = '0;
            end
         end
         ROW_RD: begin
            if (k == KW'(WIDTH / 2)) begin
               state_n = ROW_WR;
               k_n     = '0;
            end else begin
               k_n = k + KW'(1);
            end
         end
         ROW_WR: begin
            if (k == KW'(WIDTH / 2 - 1)) begin
               k_n = '0;
               if (line == LW'(HEIGHT - 1)) begin
                  state_n = COL_RD;
                  line_n  = '0;
               end else begin
                  state_n = ROW_RD;
                  line_n  = line + LW'(1);
               end
            end else begin
               k_n = k + KW'(1);
            end
         end
         COL_RD: begin
            if (k == KW'(HEIGHT / 2)) begin
               state_n = COL_WR;
               k_n     = '0;
            end else begin
               k_n = k + KW'(1);
            end
         end
         COL_WR: begin
            if (k == KW'(HEIGHT / 2 - 1)) begin
               k_n = '0;
               if (line == LW'(WIDTH - 1)) begin
                  state_n = DONE;
                  line_n  = '0;
               end else begin
                  state_n = COL_RD;
                  line_n  = line + LW'(1);
               end
            end else begin
               k_n = k + KW'(1);
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // outputs are derived from the next state so they can be registered
   always_comb begin
      en_n   = 1'b0;
      we_n   = 1'b0;
      a1_n   = '0;
      a2_n   = '0;
      d1_n   = '0;
      d2_n   = '0;
      busy_n = state_n inside {ROW_RD, ROW_WR, COL_RD, COL_WR};
      done_n = (state_n == DONE);
      row_n  = state_n inside {ROW_RD, ROW_WR};
      nh     = row_n ? WIDTH / 2 : HEIGHT / 2;
      kk     = int'(k_n);
      ln     = int'(line_n);
      p1     = 0;
      p2     = 0;
      if (state_n == ROW_RD || state_n == COL_RD) begin
         if (kk < nh) begin
            en_n = 1'b1;
            p1   = 2 * kk;
            p2   = 2 * kk + 1;
         end
      end else if (state_n == ROW_WR || state_n == COL_WR) begin
         en_n = 1'b1;
         we_n = 1'b1;
         p1   = kk;
         p2   = nh + kk;
         // forward the pair landing this cycle (single-pair lines)
         if (cap && cap_idx == k_n) begin
            d1_n = l_new;
            d2_n = h_new;
         end else begin
            d1_n = lbuf[k_n[BW-1:0]];
            d2_n = hbuf[k_n[BW-1:0]];
         end
      end
      if (en_n) begin
         a1_n = row_n ? AW'(ln * WIDTH + p1) : AW'(p1 * WIDTH + ln);
         a2_n = row_n ? AW'(ln * WIDTH + p2) : AW'(p2 * WIDTH + ln);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         line      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_en1   <= 1'b0;
         mem_en2   <= 1'b0;
         mem_we1   <= 1'b0;
         mem_we2   <= 1'b0;
         mem_addr1 <= '0;
         mem_addr2 <= '0;
         mem_din1  <= '0;
         mem_din2  <= '0;
      end else begin
         state     <= state_n;
         k         <= k_n;
         line      <= line_n;
         busy      <= busy_n;
         done      <= done_n;
         mem_en1   <= en_n;
         mem_en2   <= en_n;
         mem_we1   <= we_n;
         mem_we2   <= we_n;
         mem_addr1 <= a1_n;
         mem_addr2 <= a2_n;
         mem_din1  <= d1_n;
         mem_din2  <= d2_n;
      end
   end

endmodule
